// File: rtl/mpu_store.sv
// Streams a stored matrix out of the register file in row-major order.
// Each element is read, captured, then held on a valid/ready handshake until accepted.
module mpu_store #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = 2,
  parameter int NBITS           = 2,
  parameter int MATRIX_REG_SIZE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [MBITS:0]             matrix_m_size,
  input  logic [NBITS:0]             matrix_n_size,
  input  logic [MATRIX_REG_SIZE-1:0] store_addr,
  output logic                       error,
  output logic                       ack,
  output logic                       busy,
  output logic                       read_en,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr,
  output logic [MBITS:0]             m,
  output logic [NBITS:0]             n,
  input  logic [FP-1:0]              reg_element,
  output logic [FP-1:0]              element_out,
  output logic                       element_valid,
  input  logic                       element_ready,
  output logic                       last,
  output logic                       done
);

  typedef enum logic [2:0] {
    STORE_IDLE,
    STORE_READ,
    STORE_WAIT,
    STORE_SEND,
    STORE_DONE
  } state_t;

  localparam logic [MBITS:0] M_LIM = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_LIM = (NBITS+1)'(N);
  localparam logic [MBITS:0] M_ONE = (MBITS+1)'(1);
  localparam logic [NBITS:0] N_ONE = (NBITS+1)'(1);

  state_t         state, state_next;
  logic [MBITS:0] m_size_q, row_q, row_d, m_d;
  logic [NBITS:0] n_size_q, col_q, col_d, n_d;
  logic           req_ok, start, accept, at_last_col, at_last_row;
  logic           error_d, ack_d, busy_d, read_en_d, valid_d, last_d, done_d;
  logic [FP-1:0]  element_d;

  assign req_ok      = (matrix_m_size != '0) && (matrix_n_size != '0) &&
                       (matrix_m_size <= M_LIM) && (matrix_n_size <= N_LIM);
  assign start       = (state == STORE_IDLE) && en && req_ok;
  assign accept      = element_valid && element_ready;
  assign at_last_col = (col_q == n_size_q - N_ONE);
  assign at_last_row = (row_q == m_size_q - M_ONE);

  // Everything, including the element datapath, clears on reset so outputs read 0 at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= STORE_IDLE;
      m_size_q       <= '0;
      n_size_q       <= '0;
      reg_store_addr <= '0;
      row_q          <= '0;
      col_q          <= '0;
      error          <= 1'b0;
      ack            <= 1'b0;
      busy           <= 1'b0;
      read_en        <= 1'b0;
      m              <= '0;
      n              <= '0;
      element_out    <= '0;
      element_valid  <= 1'b0;
      last           <= 1'b0;
      done           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state         <= state_next;
      row_q         <= row_d;
      col_q         <= col_d;
      error         <= error_d;
      ack           <= ack_d;
      busy          <= busy_d;
      read_en       <= read_en_d;
      m             <= m_d;
      n             <= n_d;
      element_out   <= element_d;
      element_valid <= valid_d;
      last          <= last_d;
      done          <= done_d;
      if (start) begin
        m_size_q       <= matrix_m_size;
        n_size_q       <= matrix_n_size;
        reg_store_addr <= store_addr;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      STORE_IDLE: if (start) state_next = STORE_READ;
      STORE_READ: state_next = STORE_WAIT;
      STORE_WAIT: state_next = STORE_SEND;
      STORE_SEND: if (accept) state_next = last ? STORE_DONE : STORE_READ;
      STORE_DONE: state_next = STORE_IDLE;
      default:    state_next = STORE_IDLE;
    endcase
  end

  // All outputs are decoded from the next state so they land in flops, never from a raw input.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    row_d     = row_q;
    col_d     = col_q;
    error_d   = error;
    m_d       = m;
    n_d       = n;
    element_d = element_out;
    if (start) begin
      row_d = '0;
      col_d = '0;
    end else if ((state == STORE_SEND) && accept) begin
      if (at_last_col) begin
        col_d = '0;
        row_d = row_q + M_ONE;
      end else begin
        col_d = col_q + N_ONE;
      end
    end
    if ((state == STORE_IDLE) && en) error_d = !req_ok;
    if (state_next == STORE_READ) begin
      m_d = row_d;
      n_d = col_d;
    end
    if (state == STORE_WAIT) element_d = reg_element;
    ack_d     = (state == STORE_IDLE) && (state_next == STORE_READ);
    busy_d    = (state_next != STORE_IDLE);
    read_en_d = (state_next == STORE_READ);
    valid_d   = (state_next == STORE_SEND);
    last_d    = (state_next == STORE_SEND) && at_last_row && at_last_col;
    done_d    = (state_next == STORE_DONE);
  end

endmodule
